// File: rtl/router_pkg.sv
// Shared header-field layout and counter sizing for the packet-aware router FIFO.
package router_pkg;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;

  // Packet counter holds payload_len + 1, which needs one bit less than a byte.
  function automatic int cnt_width(input int data_w);
    return data_w - 1;
  endfunction

  function automatic logic [31:0] payload_len(input logic [31:0] header);
    return header >> LEN_LSB;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-port register array: synchronous write, combinational read.
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: stores header tag per byte, tracks packet
// boundaries on the read side and reports occupancy and sticky error flags.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       soft_reset,
  input  logic                       we,
  input  logic                       re,
  input  logic                       lfd_state,
  input  logic [DATA_W-1:0]          datain,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [DATA_W-1:0]          dataout,
  output logic                       dout_valid,
  output logic                       sop,
  output logic                       eop,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = cnt_width(DATA_W);

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    fill_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_load;
  logic [DATA_W:0]  rd_entry;
  logic             wr_ok, rd_ok;

  // Flags are registered, so full/empty here reflect the current fill_level.
  assign wr_ok = we && !full  && !soft_reset;
  assign rd_ok = re && !empty && !soft_reset;

  assign cnt_load = CNT_W'(payload_len(32'(rd_entry[DATA_W-1:0]))) + CNT_W'(1);

  always_comb begin
    fill_next = fill_level;
    case ({wr_ok, rd_ok})
      2'b10:   fill_next = fill_level + LW'(1);
      2'b01:   fill_next = fill_level - LW'(1);
      default: fill_next = fill_level;
    endcase
  end

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data ({lfd_state, datain}),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      fill_level  <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      dataout     <= '0;
      dout_valid  <= 1'b0;
      sop         <= 1'b0;
      eop         <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      cnt_reg     <= '0;
    end else if (soft_reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      fill_level  <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      dataout     <= '0;
      dout_valid  <= 1'b0;
      sop         <= 1'b0;
      eop         <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      fill_level  <= fill_next;
      full        <= (fill_next == LW'(DEPTH));
      empty       <= (fill_next == '0);
      almost_full <= (fill_next >= LW'(DEPTH - AF_MARGIN));
      if (we && full)  overflow  <= 1'b1;
      if (re && empty) underflow <= 1'b1;
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);

      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        dataout    <= rd_entry[DATA_W-1:0];
        dout_valid <= 1'b1;
        sop        <= rd_entry[DATA_W];
        // A header always reloads, even if the previous packet was truncated.
        if (rd_entry[DATA_W]) begin
          cnt_reg <= cnt_load;
          eop     <= 1'b0;
        end else if (cnt_reg > CNT_W'(1)) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          eop     <= 1'b0;
        end else if (cnt_reg == CNT_W'(1)) begin
          cnt_reg <= '0;
          eop     <= 1'b1;
        end else begin
          eop     <= 1'b0;
        end
      end else begin
        dout_valid <= 1'b0;
        sop        <= 1'b0;
        eop        <= 1'b0;
      end
    end
  end

endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
- Parametrised, packet-aware synchronous FIFO for the router output channels; next generation of the fixed 8-bit/16-deep router FIFO.
- Stores each byte with its header tag (lfd_state) and tracks packet boundaries on the read side from the header length field.
- Adds registered sop/eop markers, occupancy level, an almost-full threshold and sticky overflow/underflow error flags.
- Sits between the router input sync/FSM and each of the output ports.

Parameters:
- DATA_W, 8, byte width; header = {payload_len[DATA_W-1:2], addr[1:0]}.
- DEPTH, 16, number of entries; power of two, at least 4.
- AF_MARGIN, 2, almost_full asserts when fill_level >= DEPTH-AF_MARGIN.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- soft_reset  in  1  synchronous flush; overrides we/re.
- we  in  1  write request.
- re  in  1  read request.
- lfd_state  in  1  current datain is a header byte.
- datain  in  DATA_W  write data.
- full  out  1  fill_level == DEPTH.
- empty  out  1  fill_level == 0.
- almost_full  out  1  threshold flag, see AF_MARGIN.
- fill_level  out  $clog2(DEPTH)+1  occupancy.
- dataout  out  DATA_W  registered read data.
- dout_valid  out  1  dataout updated this cycle.
- sop  out  1  dataout is a header byte; qualified by dout_valid.
- eop  out  1  dataout is the last byte (parity) of a packet; qualified by dout_valid.
- overflow  out  1  sticky; set by a write while full.
- underflow  out  1  sticky; set by a read while empty.

Behaviour:
- Reset:
  - resetn low clears pointers, fill_level, dataout, dout_valid, sop, eop, overflow, underflow and the packet counter.
  - After reset: empty=1, all other outputs 0. Memory contents are don't-care.
- soft_reset (synchronous) has the same clearing effect at the next edge; any we/re in that cycle is ignored.
- Storage: DEPTH x (DATA_W+1) entries; bit DATA_W holds lfd_state. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Write:
  - Accepted when we && !full; stores {lfd_state, datain}.
  - we && full drops the data, leaves pointers unchanged and sets overflow.
- Read:
  - Accepted when re && !empty.
  - Next edge: dataout <= entry data, dout_valid=1, sop=tag. Latency is 1 cycle.
  - With no accepted read, dout_valid=sop=eop=0 and dataout holds its last value (no high-Z).
  - re && empty sets underflow and changes nothing else.
- Simultaneous accepted read and write: both happen and fill_level is unchanged.
  - While full, the write is rejected, because full is evaluated before the read.
  - While empty, the read is rejected; there is no fall-through.
- Flags: full, empty and almost_full are registered, derived from the next-state fill_level, so they are valid in the same cycle fill_level updates.
- Packet counter (width DATA_W-1), run on the read side:
  - Read of a tagged entry loads count = payload_len + 1 (payload bytes plus parity); eop=0.
  - Read of an untagged entry with count>1 decrements count.
  - Read of an untagged entry with count==1 asserts eop and sets count to 0.
  - Untagged read with count==0 (stray byte) gives eop=0 and count stays 0.
  - Header with payload_len==0: count loads 1 and the next byte read is eop.
  - A tagged read while count!=0 (truncated packet) reloads the counter; no eop for the previous packet.
- resetn or soft_reset mid-packet discards the partial packet and clears the counter.

Decomposition:
- Package router_pkg:
  - header field constants: ADDR_LSB=0, ADDR_W=2, LEN_LSB=2.
  - helper function for the payload-length extract.
  - packet counter width, derived from DATA_W.
- One sub-module, router_fifo_mem: dual-port register array with synchronous write and combinational read, parametrised on width and depth.
- Flags, pointers and the packet counter stay in the top level.

Test Plan (DATA_W=8, DEPTH=16, AF_MARGIN=2):
1. Reset, then idle -> empty=1, full=0, fill_level=0, dataout=8'h00, overflow=underflow=0.
2. Write header 8'h31 (len 12, addr 01) with lfd_state=1, then 12 random payload bytes and a parity byte -> fill_level=14, almost_full=1. Then read 14 -> byte order preserved, sop only on 8'h31, eop only on the 14th dout_valid, empty=1 afterwards.
3. Write 16 bytes, then a 17th -> full=1, overflow=1, fill_level=16; read-back yields the first 16 bytes unchanged. Then re at empty -> underflow=1.
4. Repeat 20 cycles of 5 writes / 5 reads to force pointer wrap, with we&&re together at fill_level=5 -> fill_level stays 5 and data stays FIFO-ordered.
5. Header 8'h00 (len 0) plus one parity byte -> sop on the first read, eop on the second.
6. soft_reset after 6 bytes of a 14-byte packet have been read -> next cycle empty=1, fill_level=0, dout_valid=0. The next packet's eop lands correctly. Repeat with resetn low asynchronously mid-read -> outputs clear immediately, without waiting for a clock edge.
